// File: rtl/megarom_pkg.sv
// megarom_pkg: shared types and constants
// for the MSX MegaROM mapper slice.
package megarom_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_HOLD,
    WR_REQ
  } state_t;

  localparam logic [15:0] PAGE1_BASE = 16'h4000;
  localparam logic [15:0] PAGE2_BASE = 16'h8000;

  typedef logic [7:0] bank_reg_t;

endpackage

// File: rtl/megarom_mapper_if.sv
// megarom_mapper_if: single-outstanding
// req/ack RAM port of the mapper.
interface megarom_mapper_if #(
  parameter int RAM_AW = 24
);

  logic              MEM_REQ;
  logic              MEM_WE;
  logic [RAM_AW-1:0] MEM_ADDR;
  logic [7:0]        MEM_WDATA;
  logic              MEM_ACK;
  logic [7:0]        MEM_RDATA;

  modport master (
    output MEM_REQ, MEM_WE,
    output MEM_ADDR, MEM_WDATA,
    input  MEM_ACK, MEM_RDATA
  );

  modport slave (
    input  MEM_REQ, MEM_WE,
    input  MEM_ADDR, MEM_WDATA,
    output MEM_ACK, MEM_RDATA
  );

endinterface

// File: rtl/megarom_bank_decode.sv
// megarom_bank_decode: bank-register address
// match plus bank index/offset split.
module megarom_bank_decode
  import megarom_pkg::*;
(
  input  logic [15:0] addr,
  input  logic [15:0] reg_addr [4],
  input  logic [15:0] addr_mask,
  input  logic        is_16k,
  output logic [3:0]  hit,
  output logic [1:0]  idx,
  output logic [13:0] offset
);

  // match all four registers; split address
  always_comb begin
    hit = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      hit[i] = ((addr ^ reg_addr[i])
               & ~addr_mask) == 16'h0000;
    end
    if (is_16k) begin
      idx    = {1'b0, addr[15]};
      offset = addr[13:0];
    end else begin
      idx    = addr[14:13] ^ 2'b10;
      offset = {1'b0, addr[12:0]};
    end
  end

endmodule

// File: rtl/megarom_mapper.sv
// megarom_mapper: MSX MegaROM bank registers
// and Z80-to-RAM access sequencer.
module megarom_mapper
  import megarom_pkg::*;
#(
  parameter int RAM_AW = 24
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BUS_RESET_n,
  input  logic              SLTSL_n,
  input  logic              MERQ_n,
  input  logic              RD_n,
  input  logic              WR_n,
  input  logic [15:0]       ADDR,
  input  logic [7:0]        DIN,
  output logic [7:0]        DOUT,
  output logic              BUSDIR_n,
  output logic              WAIT_n,
  input  logic [15:0]       BANK_REG_ADDR [4],
  input  logic [15:0]       BANK_REG_ADDR_MASK,
  input  logic [7:0]        BANK_REG_MASK,
  input  logic [7:0]        BANK_REG_INIT [4],
  input  logic              WRITE_PROTECT,
  input  logic              IS_16K_BANK,
  input  logic              CS1_MASK,
  input  logic              CS2_MASK,
  input  logic [RAM_AW-1:0] MEM_TOP_ADDR,
  megarom_mapper_if.master  mem
);

  state_t            state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  bank_reg_t         bank_q [4];
  bank_reg_t         bank_d [4];
  logic [7:0]        dout_q, dout_d;
  logic              busdir_n_q, busdir_n_d;
  logic              wait_n_q, wait_n_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [RAM_AW-1:0] maddr_q, maddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              pend_v_q, pend_v_d;
  logic [RAM_AW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic              abort_q, abort_d;

  logic [3:0]        hit;
  logic [1:0]        idx;
  logic [13:0]       offset;
  logic [21:0]       rel;
  logic [RAM_AW-1:0] acc_addr;
  logic              rd_ev, wr_ev;
  logic              in_page, rd_go, wr_go;

  megarom_bank_decode u_dec (
    .addr      (ADDR),
    .reg_addr  (BANK_REG_ADDR),
    .addr_mask (BANK_REG_ADDR_MASK),
    .is_16k    (IS_16K_BANK),
    .hit       (hit),
    .idx       (idx),
    .offset    (offset)
  );

  // Event = strobe assertion edge.
  assign rd_d  = !SLTSL_n && !MERQ_n && !RD_n;
  assign wr_d  = !SLTSL_n && !MERQ_n && !WR_n;
  assign rd_ev = rd_d && !rd_q;
  assign wr_ev = wr_d && !wr_q;

  assign in_page =
    (ADDR[15:14] == PAGE1_BASE[15:14]
     && !CS1_MASK) ||
    (ADDR[15:14] == PAGE2_BASE[15:14]
     && !CS2_MASK);

  assign rd_go = rd_ev && in_page
                 && BUS_RESET_n;
  assign wr_go = wr_ev && in_page
                 && (hit == 4'b0000)
                 && !WRITE_PROTECT
                 && BUS_RESET_n;

  assign rel = IS_16K_BANK
    ? {bank_q[idx], offset}
    : {1'b0, bank_q[idx], offset[12:0]};
  assign acc_addr =
    MEM_TOP_ADDR + RAM_AW'(rel);

  // Bank registers and access sequencer.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    dout_d      = dout_q;
    busdir_n_d  = busdir_n_q;
    wait_n_d    = wait_n_q;
    req_d       = req_q;
    we_d        = we_q;
    maddr_d     = maddr_q;
    wdata_d     = wdata_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    abort_d     = abort_q;

    if (!BUS_RESET_n) begin
      bank_d = BANK_REG_INIT;
    end else if (wr_ev) begin
      for (int i = 0; i < 4; i++) begin
        if (hit[i]) begin
          bank_d[i] = DIN & BANK_REG_MASK;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (pend_v_q) begin
          state_d  = WR_REQ;
          req_d    = 1'b1;
          we_d     = 1'b1;
          maddr_d  = pend_addr_q;
          wdata_d  = pend_data_q;
          pend_v_d = 1'b0;
        end else if (rd_go) begin
          state_d  = RD_REQ;
          req_d    = 1'b1;
          we_d     = 1'b0;
          maddr_d  = acc_addr;
          wait_n_d = 1'b0;
        end else if (wr_go) begin
          state_d  = WR_REQ;
          req_d    = 1'b1;
          we_d     = 1'b1;
          maddr_d  = acc_addr;
          wdata_d  = DIN;
        end
      end
      RD_REQ: begin
        if (!BUS_RESET_n) begin
          abort_d  = 1'b1;
          wait_n_d = 1'b1;
        end
        if (mem.MEM_ACK) begin
          req_d    = 1'b0;
          wait_n_d = 1'b1;
          if (abort_q || !BUS_RESET_n) begin
            state_d = IDLE;
          end else begin
            state_d    = RD_HOLD;
            dout_d     = mem.MEM_RDATA;
            busdir_n_d = 1'b0;
          end
        end
      end
      RD_HOLD: begin
        if (!rd_d || !BUS_RESET_n) begin
          state_d    = IDLE;
          busdir_n_d = 1'b1;
        end
      end
      WR_REQ: begin
        if (!BUS_RESET_n) begin
          pend_v_d = 1'b0;
        end else if (wr_go && !pend_v_q) begin
          pend_v_d    = 1'b1;
          pend_addr_d = acc_addr;
          pend_data_d = DIN;
        end
        if (mem.MEM_ACK) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      bank_q      <= BANK_REG_INIT;
      dout_q      <= 8'h00;
      busdir_n_q  <= 1'b1;
      wait_n_q    <= 1'b1;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      maddr_q     <= '0;
      wdata_q     <= 8'h00;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= 8'h00;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      bank_q      <= bank_d;
      dout_q      <= dout_d;
      busdir_n_q  <= busdir_n_d;
      wait_n_q    <= wait_n_d;
      req_q       <= req_d;
      we_q        <= we_d;
      maddr_q     <= maddr_d;
      wdata_q     <= wdata_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      abort_q     <= abort_d;
    end
  end

  assign DOUT          = dout_q;
  assign BUSDIR_n      = busdir_n_q;
  assign WAIT_n        = wait_n_q;
  assign mem.MEM_REQ   = req_q;
  assign mem.MEM_WE    = we_q;
  assign mem.MEM_ADDR  = maddr_q;
  assign mem.MEM_WDATA = wdata_q;

endmodule

// File: tb/tb_megarom_mapper.sv
// tb_megarom_mapper: vector table plus
// RAM-side scoreboard for megarom_mapper.
module tb_megarom_mapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_rst_n = 1'b1;
  logic        sltsl_n = 1'b1;
  logic        merq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [15:0] addr = 16'h0;
  logic [7:0]  din = 8'h0;
  logic [7:0]  dout;
  logic        busdir_n;
  logic        wait_n;
  logic [15:0] bra [4];
  logic [15:0] bra_mask = 16'h07FF;
  logic [7:0]  br_mask = 8'h1F;
  logic [7:0]  br_init [4];
  logic        wp = 1'b1;
  logic        is16k = 1'b0;
  logic        cs1m = 1'b0;
  logic        cs2m = 1'b0;
  logic [23:0] top = 24'h100000;

  megarom_mapper_if #(.RAM_AW(24)) mem ();

  megarom_mapper #(.RAM_AW(24)) dut (
    .CLK                (clk),
    .RESET              (rst),
    .BUS_RESET_n        (bus_rst_n),
    .SLTSL_n            (sltsl_n),
    .MERQ_n             (merq_n),
    .RD_n               (rd_n),
    .WR_n               (wr_n),
    .ADDR               (addr),
    .DIN                (din),
    .DOUT               (dout),
    .BUSDIR_n           (busdir_n),
    .WAIT_n             (wait_n),
    .BANK_REG_ADDR      (bra),
    .BANK_REG_ADDR_MASK (bra_mask),
    .BANK_REG_MASK      (br_mask),
    .BANK_REG_INIT      (br_init),
    .WRITE_PROTECT      (wp),
    .IS_16K_BANK        (is16k),
    .CS1_MASK           (cs1m),
    .CS2_MASK           (cs2m),
    .MEM_TOP_ADDR       (top),
    .mem                (mem.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        k16, wp, c1, c2, wr;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        req;
    logic [23:0] maddr;
    logic [7:0]  rdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  vec_t tbl [14];
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, req);
    end
  endtask

  task automatic strobe(input logic w,
                        input logic [15:0] a,
                        input logic [7:0] d);
    addr    = a;
    din     = d;
    sltsl_n = 1'b0;
    merq_n  = 1'b0;
    rd_n    = w;
    wr_n    = !w;
  endtask

  task automatic idle_bus();
    sltsl_n = 1'b1;
    merq_n  = 1'b1;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
  endtask

  task automatic serve(input int dly,
                       input logic [7:0] rdata,
                       input logic do_wait);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!mem.MEM_REQ && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", mem.MEM_REQ, 1);
    if (!mem.MEM_REQ) return;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("mem_we", mem.MEM_WE, e.we);
    chk("mem_addr", mem.MEM_ADDR, e.addr);
    if (e.we)
      chk("mem_wdata", mem.MEM_WDATA, e.wdata);
    if (do_wait)
      chk("wait_req", wait_n, e.we);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("req_hold", mem.MEM_REQ, 1);
      chk("addr_hold", mem.MEM_ADDR, e.addr);
    end
    mem.MEM_RDATA = rdata;
    mem.MEM_ACK   = 1'b1;
    @(negedge clk);
    mem.MEM_ACK   = 1'b0;
    chk("req_drop", mem.MEM_REQ, 0);
  endtask

  task automatic do_access(input vec_t v);
    logic saw_req = 1'b0;
    logic saw_drv = 1'b0;
    logic saw_wt  = 1'b0;
    is16k = v.k16;
    wp    = v.wp;
    cs1m  = v.c1;
    cs2m  = v.c2;
    if (v.req)
      exp_q.push_back('{v.wr, v.maddr, v.din});
    strobe(v.wr, v.addr, v.din);
    if (v.req) begin
      serve(0, v.rdata, 1'b1);
      if (!v.wr) begin
        chk("dout", dout, v.rdata);
        chk("busdir_rd", busdir_n, 0);
        chk("wait_rel", wait_n, 1);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        saw_req |= mem.MEM_REQ;
        saw_drv |= !busdir_n;
        saw_wt  |= !wait_n;
      end
      chk("no_req", saw_req, 0);
      chk("no_drive", saw_drv, 0);
      chk("no_wait", saw_wt, 0);
    end
    idle_bus();
    @(negedge clk);
    @(negedge clk);
    chk("busdir_idle", busdir_n, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bra[0] = 16'h5000;
    bra[1] = 16'h7000;
    bra[2] = 16'h9000;
    bra[3] = 16'hB000;
    for (int i = 0; i < 4; i++)
      br_init[i] = 8'(i);
    mem.MEM_ACK   = 1'b0;
    mem.MEM_RDATA = 8'h00;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
      16'h6001, 8'h00, 1'b1, 24'h102001, 8'h5A};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
      16'h4000, 8'h00, 1'b1, 24'h100000, 8'h11};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
      16'hBFFF, 8'h00, 1'b1, 24'h107FFF, 8'hC3};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
      16'h97FF, 8'hE3, 1'b0, 24'h0, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
      16'h8000, 8'h00, 1'b1, 24'h106000, 8'h77};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
      16'h5123, 8'h25, 1'b0, 24'h0, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
      16'h4010, 8'h00, 1'b1, 24'h10A010, 8'h3C};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
      16'hA123, 8'h44, 1'b1, 24'h106123, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
      16'h4123, 8'h00, 1'b1, 24'h114123, 8'h81};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
      16'h8000, 8'h00, 1'b0, 24'h0, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
      16'h6000, 8'h99, 1'b0, 24'h0, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
      16'h5000, 8'h3F, 1'b0, 24'h0, 8'h00};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
      16'h4000, 8'h00, 1'b1, 24'h13E000, 8'hE7};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
      16'h2000, 8'h12, 1'b0, 24'h0, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_busdir", busdir_n, 1);
    chk("rst_wait", wait_n, 1);
    chk("rst_req", mem.MEM_REQ, 0);
    chk("rst_we", mem.MEM_WE, 0);
    chk("rst_addr", mem.MEM_ADDR, 0);
    chk("rst_wdata", mem.MEM_WDATA, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      do_access(tbl[i]);

    is16k = 1'b0;
    wp    = 1'b1;
    exp_q.push_back('{1'b0, 24'h102000, 8'h00});
    strobe(1'b0, 16'h6000, 8'h00);
    @(negedge clk);
    chk("br_req", mem.MEM_REQ, 1);
    chk("br_wait_lo", wait_n, 0);
    bus_rst_n = 1'b0;
    serve(5, 8'hAA, 1'b0);
    chk("br_wait_hi", wait_n, 1);
    chk("br_nodrive", busdir_n, 1);
    @(negedge clk);
    chk("br_nodrive2", busdir_n, 1);
    idle_bus();
    @(negedge clk);
    bus_rst_n = 1'b1;
    @(negedge clk);
    do_access('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
      16'h4000, 8'h00, 1'b1, 24'h100000, 8'h21});
    do_access('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
      16'h8000, 8'h00, 1'b1, 24'h104000, 8'h42});

    top = 24'hFFF000;
    wp  = 1'b0;
    exp_q.push_back('{1'b1, 24'h001000, 8'h01});
    strobe(1'b1, 16'h6000, 8'h01);
    @(negedge clk);
    chk("b2b_req1", mem.MEM_REQ, 1);
    chk("b2b_wait", wait_n, 1);
    idle_bus();
    @(negedge clk);
    exp_q.push_back('{1'b1, 24'h003004, 8'h02});
    strobe(1'b1, 16'h8004, 8'h02);
    @(negedge clk);
    idle_bus();
    serve(1, 8'h00, 1'b1);
    serve(0, 8'h00, 1'b1);
    chk("sb_drained", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    chk("b2b_idle", mem.MEM_REQ, 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
